// File: rtl/spi_slave_tx_sched.sv
// Transmit scheduler for spi_slave_tx: arbitrates register readback words against FIFO read bursts.
// Define SPI_TX_SCHED_RR_EN for round-robin arbitration in IDLE; fixed reg-first priority otherwise.
module spi_slave_tx_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  sclk,
    input  logic                  rstn,
    input  logic                  reg_req,
    input  logic [DATA_WIDTH-1:0] reg_data,
    input  logic [7:0]            reg_len,
    output logic                  reg_gnt,
    input  logic                  rd_start,
    input  logic [CNT_WIDTH-1:0]  rd_words,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_valid,
    output logic                  fifo_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_data_valid,
    output logic [7:0]            tx_counter_in,
    output logic                  tx_counter_in_upd,
    input  logic                  tx_done,
    output logic                  busy,
    output logic                  underrun
);

    typedef enum logic [1:0] {IDLE, REG, BURST} state_e;

    localparam logic [7:0] MAX_LEN = 8'(DATA_WIDTH - 1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 rd_pend_q, rd_pend_d;
    logic                 underrun_q, underrun_d;
    logic                 burst_cand, pick_reg;
`ifdef SPI_TX_SCHED_RR_EN
    logic                 last_reg_q, last_reg_d;
`endif

    assign burst_cand = rd_pend_q & fifo_valid;

`ifdef SPI_TX_SCHED_RR_EN
    assign pick_reg = reg_req & (~burst_cand | ~last_reg_q);
`else
    assign pick_reg = reg_req;
`endif

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rd_pend_d     = rd_pend_q;
        underrun_d    = underrun_q;
        reg_gnt       = 1'b0;
        fifo_ready    = 1'b0;
        tx_data       = '0;
        tx_data_valid = 1'b0;
        tx_counter_in = '0;
`ifdef SPI_TX_SCHED_RR_EN
        last_reg_d    = last_reg_q;
`endif
        // Loads are combinational, so they are gated by reset to keep all outputs at 0 while it is held.
        if (rstn) begin
            unique case (state_q)
                IDLE: begin
                    if (rd_start && !rd_pend_q && rd_words != '0) begin
                        rd_pend_d = 1'b1;
                        cnt_d     = rd_words;
                    end
                    if (pick_reg) begin
                        tx_data_valid = 1'b1;
                        tx_data       = reg_data;
                        tx_counter_in = (reg_len > MAX_LEN) ? MAX_LEN : reg_len;
                        reg_gnt       = 1'b1;
                        state_d       = REG;
`ifdef SPI_TX_SCHED_RR_EN
                        last_reg_d    = 1'b1;
`endif
                    end else if (burst_cand) begin
                        tx_data_valid = 1'b1;
                        tx_data       = fifo_data;
                        tx_counter_in = MAX_LEN;
                        fifo_ready    = 1'b1;
                        cnt_d         = cnt_q - 1'b1;
                        rd_pend_d     = 1'b0;
                        state_d       = BURST;
`ifdef SPI_TX_SCHED_RR_EN
                        last_reg_d    = 1'b0;
`endif
                    end
                end
                REG: begin
                    if (tx_done) state_d = IDLE;
                end
                BURST: begin
                    if (tx_done) begin
                        if (cnt_q == '0) begin
                            state_d = IDLE;
                        end else begin
                            // The next word loads in the done cycle so the bit stream has no gap.
                            tx_data_valid = 1'b1;
                            tx_counter_in = MAX_LEN;
                            cnt_d         = cnt_q - 1'b1;
                            if (fifo_valid) begin
                                tx_data    = fifo_data;
                                fifo_ready = 1'b1;
                            end else begin
                                underrun_d = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign tx_counter_in_upd = tx_data_valid;
    assign busy              = (state_q != IDLE) | rd_pend_q;
    assign underrun          = underrun_q;

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_pend_q  <= 1'b0;
            underrun_q <= 1'b0;
`ifdef SPI_TX_SCHED_RR_EN
            last_reg_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_pend_q  <= rd_pend_d;
            underrun_q <= underrun_d;
`ifdef SPI_TX_SCHED_RR_EN
            last_reg_q <= last_reg_d;
`endif
        end
    end

endmodule

// File: tb/tb_spi_slave_tx_sched.sv
// Directed bench for spi_slave_tx_sched: table of register readback vectors plus hand-written burst,
// underrun, contention (both arbitration builds), busy/zero-length rd_start and mid-burst reset sequences.
module tb_spi_slave_tx_sched;

    logic        sclk = 1'b0;
    logic        rstn;
    logic        reg_req;
    logic [31:0] reg_data;
    logic [7:0]  reg_len;
    logic        reg_gnt;
    logic        rd_start;
    logic [15:0] rd_words;
    logic [31:0] fifo_data;
    logic        fifo_valid;
    logic        fifo_ready;
    logic [31:0] tx_data;
    logic        tx_data_valid;
    logic [7:0]  tx_counter_in;
    logic        tx_counter_in_upd;
    logic        tx_done;
    logic        busy;
    logic        underrun;

    int n_cmp  = 0;
    int n_fail = 0;
    int pops   = 0;
    int pops_base;

    always #5 sclk = ~sclk;

    spi_slave_tx_sched #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .sclk(sclk), .rstn(rstn),
        .reg_req(reg_req), .reg_data(reg_data), .reg_len(reg_len), .reg_gnt(reg_gnt),
        .rd_start(rd_start), .rd_words(rd_words),
        .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_ready(fifo_ready),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_counter_in(tx_counter_in),
        .tx_counter_in_upd(tx_counter_in_upd), .tx_done(tx_done),
        .busy(busy), .underrun(underrun)
    );

    always @(posedge sclk) if (fifo_ready) pops++;

    typedef struct {
        logic        req;
        logic [31:0] data;
        logic [7:0]  len;
        logic        exp_gnt;
        logic [31:0] exp_data;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge sclk);
    endtask

    task automatic check_load(input string name, input logic [31:0] data, input logic [7:0] cnt,
                              input logic rdy);
        check({name, ".valid"}, 64'(tx_data_valid), 64'(1));
        check({name, ".upd"},   64'(tx_counter_in_upd), 64'(1));
        check({name, ".data"},  64'(tx_data), 64'(data));
        check({name, ".cnt"},   64'(tx_counter_in), 64'(cnt));
        check({name, ".ready"}, 64'(fifo_ready), 64'(rdy));
    endtask

    task automatic check_noload(input string name);
        check({name, ".valid"}, 64'(tx_data_valid), 64'(0));
        check({name, ".ready"}, 64'(fifo_ready), 64'(0));
        check({name, ".gnt"},   64'(reg_gnt), 64'(0));
    endtask

    task automatic do_reset();
        tick();
        rstn = 1'b0; reg_req = 0; reg_data = 0; reg_len = 0; rd_start = 0; rd_words = 0;
        fifo_data = 0; fifo_valid = 0; tx_done = 0;
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; reg_req = 0; reg_data = 0; reg_len = 0; rd_start = 0; rd_words = 0;
        fifo_data = 0; fifo_valid = 0; tx_done = 0;
        #1;
        check("rst.valid", 64'(tx_data_valid), 64'(0));
        check("rst.data",  64'(tx_data), 64'(0));
        check("rst.cnt",   64'(tx_counter_in), 64'(0));
        check("rst.busy",  64'(busy), 64'(0));
        check("rst.underrun", 64'(underrun), 64'(0));
        do_reset();

        // ---- register readback table ----
        vecs[0] = '{1'b1, 32'hA500_0000, 8'd7,   1'b1, 32'hA500_0000, 8'd7};
        vecs[1] = '{1'b1, 32'hDEAD_BEEF, 8'd31,  1'b1, 32'hDEAD_BEEF, 8'd31};
        vecs[2] = '{1'b1, 32'h1234_5678, 8'd40,  1'b1, 32'h1234_5678, 8'd31};
        vecs[3] = '{1'b1, 32'hFFFF_FFFF, 8'd255, 1'b1, 32'hFFFF_FFFF, 8'd31};
        vecs[4] = '{1'b1, 32'h8000_0000, 8'd0,   1'b1, 32'h8000_0000, 8'd0};
        vecs[5] = '{1'b1, 32'h0F0F_0F0F, 8'd32,  1'b1, 32'h0F0F_0F0F, 8'd31};
        vecs[6] = '{1'b0, 32'hCAFE_F00D, 8'd7,   1'b0, 32'h0000_0000, 8'd0};

        for (int i = 0; i < 7; i++) begin
            tick();
            reg_req = vecs[i].req; reg_data = vecs[i].data; reg_len = vecs[i].len;
            #1;
            check($sformatf("vec%0d.gnt", i),   64'(reg_gnt), 64'(vecs[i].exp_gnt));
            check($sformatf("vec%0d.valid", i), 64'(tx_data_valid), 64'(vecs[i].exp_gnt));
            check($sformatf("vec%0d.upd", i),   64'(tx_counter_in_upd), 64'(vecs[i].exp_gnt));
            check($sformatf("vec%0d.data", i),  64'(tx_data), 64'(vecs[i].exp_data));
            check($sformatf("vec%0d.cnt", i),   64'(tx_counter_in), 64'(vecs[i].exp_cnt));
            tick();
            reg_req = 1'b0;
            #1;
            check($sformatf("vec%0d.busy", i), 64'(busy), 64'(vecs[i].exp_gnt));
            if (vecs[i].exp_gnt) begin
                repeat (int'(vecs[i].exp_cnt)) tick();
                tx_done = 1'b1;
                #1 check_noload($sformatf("vec%0d.done", i));
                tick();
                tx_done = 1'b0;
                #1 check($sformatf("vec%0d.idle", i), 64'(busy), 64'(0));
            end
        end

        // ---- 3-word burst, gapless loads in done cycles ----
        pops_base = pops;
        tick(); rd_start = 1; rd_words = 3;
        #1 check("b3.busy_pre", 64'(busy), 64'(0));
        tick(); rd_start = 0;
        #1 check("b3.busy_wait", 64'(busy), 64'(1));
        check_noload("b3.wait");
        tick(); fifo_valid = 1; fifo_data = 32'h1111_1111;
        #1 check_load("b3.w0", 32'h1111_1111, 8'd31, 1'b1);
        tick(); fifo_valid = 0;
        #1 check_noload("b3.shift");
        for (int w = 1; w < 3; w++) begin
            repeat (2) tick();
            tx_done = 1; fifo_valid = 1; fifo_data = (w == 1) ? 32'h2222_2222 : 32'h3333_3333;
            #1 check_load($sformatf("b3.w%0d", w), fifo_data, 8'd31, 1'b1);
            tick(); tx_done = 0; fifo_valid = 0;
        end
        tick(); tx_done = 1; fifo_valid = 1; fifo_data = 32'h4444_4444;
        #1 check_noload("b3.last_done");
        check("b3.busy_last", 64'(busy), 64'(1));
        tick(); tx_done = 0; fifo_valid = 0;
        #1 check("b3.busy_end", 64'(busy), 64'(0));
        check("b3.pops", 64'(pops - pops_base), 64'(3));

        // ---- underrun: second word shifts zeros ----
        pops_base = pops;
        tick(); rd_start = 1; rd_words = 2; fifo_valid = 1; fifo_data = 32'hAAAA_AAAA;
        #1 check_noload("ur.latch");
        tick(); rd_start = 0;
        #1 check_load("ur.w0", 32'hAAAA_AAAA, 8'd31, 1'b1);
        tick(); fifo_valid = 0;
        tick(); tx_done = 1;
        #1 check_load("ur.w1", 32'h0, 8'd31, 1'b0);
        check("ur.flag_pre", 64'(underrun), 64'(0));
        tick(); tx_done = 0;
        #1 check("ur.flag", 64'(underrun), 64'(1));
        tick(); tx_done = 1;
        #1 check_noload("ur.last_done");
        tick(); tx_done = 0;
        #1 check("ur.busy_end", 64'(busy), 64'(0));
        check("ur.sticky", 64'(underrun), 64'(1));
        check("ur.pops", 64'(pops - pops_base), 64'(1));

        // ---- reset midway through a burst word ----
        tick(); rd_start = 1; rd_words = 2; fifo_valid = 1; fifo_data = 32'h5555_5555;
        tick(); rd_start = 0;
        tick(); fifo_valid = 0;
        tick();
        rstn = 0; reg_req = 1; reg_data = 32'h9999_9999; reg_len = 3; fifo_valid = 1; tx_done = 1;
        #1;
        check("rs.valid", 64'(tx_data_valid), 64'(0));
        check("rs.upd",   64'(tx_counter_in_upd), 64'(0));
        check("rs.data",  64'(tx_data), 64'(0));
        check("rs.cnt",   64'(tx_counter_in), 64'(0));
        check("rs.ready", 64'(fifo_ready), 64'(0));
        check("rs.gnt",   64'(reg_gnt), 64'(0));
        check("rs.busy",  64'(busy), 64'(0));
        check("rs.underrun", 64'(underrun), 64'(0));
        tick(); rstn = 1; fifo_valid = 0; tx_done = 0;
        #1 check_load("rs.idle_reg", 32'h9999_9999, 8'd3, 1'b0);
        check("rs.idle_gnt", 64'(reg_gnt), 64'(1));
        tick(); reg_req = 0;
        tick(); tx_done = 1;
        tick(); tx_done = 0;
        #1 check("rs.busy_end", 64'(busy), 64'(0));

        // ---- zero-length and busy rd_start are ignored ----
        tick(); rd_start = 1; rd_words = 0;
        tick(); rd_start = 0;
        #1 check("zl.busy", 64'(busy), 64'(0));
        tick(); rd_start = 1; rd_words = 2; fifo_valid = 1; fifo_data = 32'h7777_7777;
        tick(); rd_start = 0;
        #1 check_load("bz.w0", 32'h7777_7777, 8'd31, 1'b1);
        tick(); fifo_valid = 0; rd_start = 1; rd_words = 5;
        tick(); rd_start = 0;
        tick(); tx_done = 1; fifo_valid = 1; fifo_data = 32'h8888_8888;
        #1 check_load("bz.w1", 32'h8888_8888, 8'd31, 1'b1);
        tick(); tx_done = 0; fifo_valid = 0;
        tick(); tx_done = 1;
        #1 check_noload("bz.last_done");
        tick(); tx_done = 0; fifo_valid = 1; fifo_data = 32'hBAD0_BAD0;
        #1 check("bz.busy_end", 64'(busy), 64'(0));
        check_noload("bz.no_restart");
        fifo_valid = 0;

        // ---- contention: rd_start alongside reg grant, then reg vs pending burst ----
        do_reset();
        pops_base = pops;
        tick(); reg_req = 1; reg_data = 32'h0000_00C3; reg_len = 31; rd_start = 1; rd_words = 1;
        fifo_valid = 1; fifo_data = 32'h6666_6666;
        #1 check_load("ct.reg1", 32'h0000_00C3, 8'd31, 1'b0);
        check("ct.gnt1", 64'(reg_gnt), 64'(1));
        tick(); rd_start = 0; reg_data = 32'h0000_003C;
        #1 check_noload("ct.in_reg");
        check("ct.busy", 64'(busy), 64'(1));
        tick(); tx_done = 1;
        #1 check_noload("ct.reg_done");
        tick(); tx_done = 0;
`ifdef SPI_TX_SCHED_RR_EN
        #1 check_load("ct.rr_burst", 32'h6666_6666, 8'd31, 1'b1);
        check("ct.rr_gnt", 64'(reg_gnt), 64'(0));
        tick(); fifo_valid = 0;
        tick(); tx_done = 1;
        #1 check_noload("ct.rr_bdone");
        tick(); tx_done = 0;
        #1 check_load("ct.rr_reg", 32'h0000_003C, 8'd31, 1'b0);
        check("ct.rr_gnt2", 64'(reg_gnt), 64'(1));
        tick(); reg_req = 0;
        tick(); tx_done = 1;
        tick(); tx_done = 0;
`else
        #1 check_load("ct.fp_reg", 32'h0000_003C, 8'd31, 1'b0);
        check("ct.fp_gnt", 64'(reg_gnt), 64'(1));
        tick(); reg_req = 0;
        tick(); tx_done = 1;
        tick(); tx_done = 0;
        #1 check_load("ct.fp_burst", 32'h6666_6666, 8'd31, 1'b1);
        tick(); fifo_valid = 0;
        tick(); tx_done = 1;
        tick(); tx_done = 0;
`endif
        #1 check("ct.busy_end", 64'(busy), 64'(0));
        check("ct.pops", 64'(pops - pops_base), 64'(1));

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_tx_sched.md
# spi_slave_tx_sched

Transmit scheduler that sequences `spi_slave_tx`. It shares the MISO shift datapath between two requesters: single register-readback words and multi-word memory-read bursts drawn from a read FIFO. It drives the TX block's load interface (`data`, `data_valid`, `counter_in`, `counter_in_upd`) and consumes its `done` pulse so that burst words stream back-to-back with no bit gaps. It sits in the SPI clock domain, between the command decoder / read FIFO and `spi_slave_tx`.

## Interface
- `DATA_WIDTH`, 32: word width; must match `spi_slave_tx`.
- `CNT_WIDTH`, 16: width of the burst word counter.
---
- `sclk`  in  1: clock; the same derived edge that clocks `spi_slave_tx`.
- `rstn`  in  1: asynchronous active-low reset; the top level drives it from `~cs`.
- `reg_req`  in  1: register readback word pending; held until granted.
- `reg_data`  in  DATA_WIDTH: readback word, MSB-aligned.
- `reg_len`  in  8: bit count minus 1; values above DATA_WIDTH-1 are clamped to DATA_WIDTH-1.
- `reg_gnt`  out  1: one-cycle pulse; word loaded this cycle.
- `rd_start`  in  1: pulse; request a burst.
- `rd_words`  in  CNT_WIDTH: burst length in words, sampled on `rd_start`.
- `fifo_data`  in  DATA_WIDTH: FIFO head word.
- `fifo_valid`  in  1: FIFO head valid.
- `fifo_ready`  out  1: pop; asserted in the same cycle the head word is loaded.
- `tx_data`  out  DATA_WIDTH: to `spi_slave_tx.data`.
- `tx_data_valid`  out  1: to `data_valid`.
- `tx_counter_in`  out  8: to `counter_in`.
- `tx_counter_in_upd`  out  1: to `counter_in_upd`; always equal to `tx_data_valid`.
- `tx_done`  in  1: from `spi_slave_tx.done`.
- `busy`  out  1: high when state is not IDLE or a burst is pending.
- `underrun`  out  1: sticky; the FIFO was empty when a burst word was due.

## Operation
- State machine has three states: IDLE, REG and BURST.
- A "load" means `tx_data_valid = tx_counter_in_upd = 1` for one cycle, with `tx_data` and `tx_counter_in` valid. Loads are combinational from state and inputs.
- `rd_start` is latched as `rd_pend` with `cnt = rd_words`. It is accepted only in IDLE with no burst pending. It is ignored otherwise, and ignored when `rd_words == 0`.
- **IDLE:**
  - Candidates are `reg_req`, and (`rd_pend & fifo_valid`).
  - Arbitration picks one candidate (see Configuration).
  - Reg win: load `reg_data` with `counter_in = min(reg_len, DATA_WIDTH-1)`, pulse `reg_gnt`, go to REG.
  - Burst win: load `fifo_data` with `counter_in = DATA_WIDTH-1`, pulse `fifo_ready`, set `cnt <= cnt-1`, clear `rd_pend`, go to BURST.
  - A pending burst does not start until `fifo_valid = 1`. No underrun is flagged while waiting.
- **REG:** on `tx_done`, go to IDLE. There is no chaining, so a one-bit idle gap follows a reg word.
- **BURST:** on `tx_done`:
  - If `cnt == 0`: go to IDLE.
  - Else, in the same cycle, load the next word and set `cnt <= cnt-1`:
    - If `fifo_valid = 1`: load `fifo_data` and pulse `fifo_ready`.
    - If `fifo_valid = 0`: load all-zeros, do not pulse `fifo_ready`, and set `underrun`. The slot counts as sent.
- `reg_req` during BURST waits until the burst completes.
- `tx_done` in IDLE is ignored.

## Timing
- Grant-to-load latency is 0 cycles: the load happens in the cycle the grant is decided. The state register updates on the same edge that `spi_slave_tx` samples the load.
- Burst words are gapless: the word N+1 load coincides with the word N `tx_done` cycle.
- Reset values: state IDLE; `cnt = 0`; `rd_pend = 0`; `underrun = 0`; all outputs 0, including `tx_data = 0` and `tx_counter_in = 0`.
- Reset mid-burst aborts immediately. No FIFO pops occur after reset; leftover FIFO contents are the FIFO owner's responsibility.
- `rd_start` and a reg grant in the same IDLE cycle: the burst latches, and the reg word loads if it wins arbitration. The burst then starts after the reg word completes.
- The `cnt` decrement never wraps: a load happens only when `cnt > 0`.

## Configuration
- `SPI_TX_SCHED_RR_EN`:
  - Defined: round-robin arbitration in IDLE. A `last_reg` flag is set on each reg grant and cleared on each burst grant. When both candidates are present, the requester not last granted wins. `last_reg` resets to 0.
  - Undefined: fixed priority; `reg_req` always wins, and no `last_reg` flop exists.

## Test plan
- Reg only: `reg_req`, `reg_data = 0xA5000000`, `reg_len = 7` -> `reg_gnt` pulses in the same cycle; MISO shifts 1010_0101; `tx_done` fires 8 clocks later; return to IDLE.
- Burst: `rd_start`, `rd_words = 3`, FIFO holding 0x11111111 / 0x22222222 / 0x33333333 -> 96 contiguous bits with no gaps; exactly 3 `fifo_ready` pulses; `busy` drops after the third `tx_done`.
- Underrun: `rd_words = 2`, FIFO empty after the first word -> second word shifts as zeros; `underrun = 1` and stays high; no second `fifo_ready` pulse.
- Contention: `reg_req` and a pending burst present in the same cycle -> without RR, reg is granted first; with `SPI_TX_SCHED_RR_EN`, the second contention after a reg grant goes to the burst.
- `rd_words = 2` with `reg_len = 40` (clamp check) and `rd_start` while busy -> `tx_counter_in = 31`; the second `rd_start` is ignored.
- Reset: `rstn` low midway through burst word 1 -> all outputs 0 immediately; after release, state is IDLE and `underrun = 0`.
